// File: rtl/packet_eject_local_if.sv
// Router-to-ejector link: the packet word travels downstream, and the
// registered backpressure flag travels back upstream.
interface packet_eject_local_if #(
  parameter int PACKET_SIZE = 49
);
  logic [PACKET_SIZE-1:0] eject_in;
  logic                   backpressure_wr;

  // Router side: drives packets, observes backpressure.
  modport master (
    output eject_in,
    input  backpressure_wr
  );

  // Ejector side: consumes packets, raises backpressure.
  modport slave (
    input  eject_in,
    output backpressure_wr
  );
endinterface

// File: rtl/packet_eject_local.sv
// Local ejection stage of a router node.
// Packets arriving on the ejection port are buffered in a small in-order FIFO
// and consumed by a rate-limited sink. Consumed packets are classified as
// local deliveries (counted and latency-accumulated) or misroutes. Packets that
// find the FIFO full are dropped, counted, and flagged with a sticky error.
// Packet layout: [PACKET_SIZE-1] valid, [47:32] timestamp, [31:16] source,
// [15:0] destination.
module packet_eject_local #(
  parameter int PACKET_SIZE      = 49,
  parameter int ROUTER_ID        = 0,
  parameter int FIFO_DEPTH       = 4,
  parameter int BUFFER_THRESHOLD = 1,
  parameter int DRAIN_CYCLE      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 clk_counter,
  input  logic                        sink_en,
  packet_eject_local_if.slave         eject_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [63:0]                 total_packet_recieve,
  output logic [63:0]                 total_latency,
  output logic [15:0]                 misroute_cnt,
  output logic [15:0]                 drop_cnt,
  output logic                        overflow_err,
  output logic [15:0]                 last_src
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DRAIN_W = (DRAIN_CYCLE > 1) ? $clog2(DRAIN_CYCLE) : 1;
  // The valid bit is never stored: every stored entry is valid by construction.
  localparam int ENTRY_W = PACKET_SIZE - 1;

  localparam int TS_MSB  = 47;
  localparam int TS_LSB  = 32;
  localparam int SRC_MSB = 31;
  localparam int SRC_LSB = 16;
  localparam int DST_MSB = 15;
  localparam int DST_LSB = 0;

  localparam logic [CNT_W-1:0]   DEPTH_C      = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO_C   = CNT_W'(0);
  localparam logic [PTR_W-1:0]   PTR_ONE_C    = PTR_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ZERO_C   = PTR_W'(0);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST_C = DRAIN_W'(DRAIN_CYCLE - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE_C  = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_ZERO_C = DRAIN_W'(0);
  localparam logic [15:0]        ROUTER_ID_C  = 16'(ROUTER_ID);
  localparam logic [31:0]        THRESH_C     = 32'(BUFFER_THRESHOLD);

  // Saturating 16-bit increment used by the error/misroute counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

  logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [DRAIN_W-1:0] drain_cnt_r;
  logic               backpressure_r;

  logic               valid_s;
  logic               tick_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [31:0]        free_next_s;
  logic               bp_next_s;
  logic [ENTRY_W-1:0] head_s;
  logic [15:0]        head_ts_s;
  logic [15:0]        head_src_s;
  logic [15:0]        head_dst_s;
  logic [15:0]        latency_s;

  assign eject_if.backpressure_wr = backpressure_r;

  // Handshake decode: drain tick, pop/push/drop decisions and next occupancy.
  always_comb begin
    valid_s      = eject_if.eject_in[PACKET_SIZE-1];
    tick_s       = sink_en && (drain_cnt_r == DRAIN_LAST_C);
    // Pop looks only at pre-edge occupancy, so a packet never bypasses the FIFO.
    pop_s        = tick_s && (fifo_count != CNT_ZERO_C);
    // A full FIFO still accepts a packet when the head leaves in the same edge.
    push_s       = valid_s && ((fifo_count < DEPTH_C) || pop_s);
    drop_s       = valid_s && !push_s;
    count_next_s = fifo_count;
    case ({push_s, pop_s})
      2'b10:   count_next_s = fifo_count + CNT_ONE_C;
      2'b01:   count_next_s = fifo_count - CNT_ONE_C;
      default: count_next_s = fifo_count;
    endcase
    free_next_s = 32'(DEPTH_C - count_next_s);
    bp_next_s   = (free_next_s < THRESH_C);
  end

  // Head-of-queue field extraction and modulo-2^16 latency (handles timestamp wrap).
  always_comb begin
    head_s     = mem_r[rd_ptr_r];
    head_ts_s  = head_s[TS_MSB:TS_LSB];
    head_src_s = head_s[SRC_MSB:SRC_LSB];
    head_dst_s = head_s[DST_MSB:DST_LSB];
    latency_s  = clk_counter - head_ts_s;
  end

  // FIFO storage, pointers, occupancy and registered backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
      wr_ptr_r       <= PTR_ZERO_C;
      rd_ptr_r       <= PTR_ZERO_C;
      fifo_count     <= CNT_ZERO_C;
      backpressure_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= eject_if.eject_in[ENTRY_W-1:0];
        wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      fifo_count     <= count_next_s;
      backpressure_r <= bp_next_s;
    end
  end

  // Sink rate limiter: free-running modulo-DRAIN_CYCLE counter, frozen while the sink is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_r <= DRAIN_ZERO_C;
    end else if (sink_en) begin
      if (drain_cnt_r == DRAIN_LAST_C) begin
        drain_cnt_r <= DRAIN_ZERO_C;
      end else begin
        drain_cnt_r <= drain_cnt_r + DRAIN_ONE_C;
      end
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end

  // Delivery statistics on pop, drop accounting on rejected valid packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_packet_recieve <= 64'd0;
      total_latency        <= 64'd0;
      misroute_cnt         <= 16'd0;
      drop_cnt             <= 16'd0;
      overflow_err         <= 1'b0;
      last_src             <= 16'd0;
    end else begin
      if (pop_s) begin
        if (head_dst_s == ROUTER_ID_C) begin
          total_packet_recieve <= total_packet_recieve + 64'd1;
          total_latency        <= total_latency + {48'd0, latency_s};
        end else begin
          misroute_cnt <= sat_inc16(misroute_cnt);
        end
        last_src <= head_src_s;
      end else begin
        last_src <= last_src;
      end
      if (drop_s) begin
        drop_cnt     <= sat_inc16(drop_cnt);
        overflow_err <= 1'b1;
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end

endmodule

// File: tb/tb_packet_eject_local.sv
// Directed self-checking bench for packet_eject_local.
// Instance A: ROUTER_ID=2, depth 4, drain every cycle.
// Instance B: ROUTER_ID=2, depth 4, drain every third cycle.
module tb_packet_eject_local;

  logic        clk;
  logic        rst_n;
  logic [15:0] clk_counter;
  logic        sink_a;
  logic        sink_b;

  logic [2:0]  cnt_a;
  logic [63:0] rcv_a, lat_a;
  logic [15:0] mis_a, drop_a, src_a;
  logic        ovf_a;
  logic [2:0]  cnt_b;
  logic [63:0] rcv_b, lat_b;
  logic [15:0] mis_b, drop_b, src_b;
  logic        ovf_b;

  int tests = 0;
  int fails = 0;

  packet_eject_local_if #(.PACKET_SIZE(49)) if_a ();
  packet_eject_local_if #(.PACKET_SIZE(49)) if_b ();

  packet_eject_local #(
    .PACKET_SIZE(49), .ROUTER_ID(2), .FIFO_DEPTH(4), .BUFFER_THRESHOLD(1), .DRAIN_CYCLE(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .sink_en(sink_a),
    .eject_if(if_a.slave), .fifo_count(cnt_a), .total_packet_recieve(rcv_a),
    .total_latency(lat_a), .misroute_cnt(mis_a), .drop_cnt(drop_a),
    .overflow_err(ovf_a), .last_src(src_a)
  );

  packet_eject_local #(
    .PACKET_SIZE(49), .ROUTER_ID(2), .FIFO_DEPTH(4), .BUFFER_THRESHOLD(1), .DRAIN_CYCLE(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .sink_en(sink_b),
    .eject_if(if_b.slave), .fifo_count(cnt_b), .total_packet_recieve(rcv_b),
    .total_latency(lat_b), .misroute_cnt(mis_b), .drop_cnt(drop_b),
    .overflow_err(ovf_b), .last_src(src_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] pkt(input logic v, input logic [15:0] ts,
                                      input logic [15:0] src, input logic [15:0] dst);
    return {v, ts, src, dst};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_src [4];

  initial begin
    rst_n         = 1'b0;
    sink_a        = 1'b1;
    sink_b        = 1'b0;
    clk_counter   = 16'd0;
    if_a.eject_in = 49'd0;
    if_b.eject_in = 49'd0;
    exp_src[0] = 16'h0011;
    exp_src[1] = 16'h0012;
    exp_src[2] = 16'h0013;
    exp_src[3] = 16'h0016;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_count", 64'(cnt_a), 64'd0);
    chk("rst_bp", 64'(if_a.backpressure_wr), 64'd0);
    chk("rst_rcv", rcv_a, 64'd0);
    chk("rst_lat", lat_a, 64'd0);
    chk("rst_mis", 64'(mis_a), 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_src", 64'(src_a), 64'd0);
    chk("rst_count_b", 64'(cnt_b), 64'd0);
    #2 rst_n = 1'b1;

    // VALID=0 packet is ignored
    if_a.eject_in = pkt(1'b0, 16'h1234, 16'h00AA, 16'h0002);
    step();
    chk("inv_count", 64'(cnt_a), 64'd0);
    chk("inv_drop", 64'(drop_a), 64'd0);
    step();
    chk("inv_rcv", rcv_a, 64'd0);

    // Basic receive: ts=0x10, popped at clk_counter=0x13 -> latency 3
    clk_counter   = 16'h0010;
    if_a.eject_in = pkt(1'b1, 16'h0010, 16'h0001, 16'h0002);
    step();
    chk("basic_push_count", 64'(cnt_a), 64'd1);
    chk("basic_no_bypass", rcv_a, 64'd0);
    if_a.eject_in = 49'd0;
    clk_counter   = 16'h0013;
    step();
    chk("basic_rcv", rcv_a, 64'd1);
    chk("basic_lat", lat_a, 64'd3);
    chk("basic_src", 64'(src_a), 64'd1);
    chk("basic_count", 64'(cnt_a), 64'd0);

    // Timestamp wrap: ts=0xFFFE popped at 0x0003 -> +5
    clk_counter   = 16'hFFFE;
    if_a.eject_in = pkt(1'b1, 16'hFFFE, 16'h0005, 16'h0002);
    step();
    if_a.eject_in = 49'd0;
    clk_counter   = 16'h0003;
    step();
    chk("wrap_rcv", rcv_a, 64'd2);
    chk("wrap_lat", lat_a, 64'd8);
    chk("wrap_src", 64'(src_a), 64'd5);

    // Overflow: sink stalled, six valid packets into a 4-deep FIFO
    sink_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if_a.eject_in = pkt(1'b1, 16'h0000, 16'(16'h0010 + i), 16'h0002);
      step();
      if (i == 2) begin
        chk("ovf_bp_after3", 64'(if_a.backpressure_wr), 64'd0);
        chk("ovf_count3", 64'(cnt_a), 64'd3);
      end
      if (i == 3) begin
        chk("ovf_bp_after4", 64'(if_a.backpressure_wr), 64'd1);
        chk("ovf_count4", 64'(cnt_a), 64'd4);
        chk("ovf_ovf_before_drop", 64'(ovf_a), 64'd0);
      end
    end
    chk("ovf_count", 64'(cnt_a), 64'd4);
    chk("ovf_drop", 64'(drop_a), 64'd2);
    chk("ovf_flag", 64'(ovf_a), 64'd1);
    chk("ovf_bp", 64'(if_a.backpressure_wr), 64'd1);
    chk("ovf_rcv_held", rcv_a, 64'd2);

    // Full FIFO with simultaneous push and pop
    sink_a        = 1'b1;
    clk_counter   = 16'h0100;
    if_a.eject_in = pkt(1'b1, 16'h0000, 16'h0016, 16'h0002);
    step();
    chk("full_pp_count", 64'(cnt_a), 64'd4);
    chk("full_pp_drop", 64'(drop_a), 64'd2);
    chk("full_pp_src", 64'(src_a), 64'h10);
    chk("full_pp_rcv", rcv_a, 64'd3);
    chk("full_pp_bp", 64'(if_a.backpressure_wr), 64'd1);

    // Drain the remaining four in arrival order
    if_a.eject_in = 49'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_src", 64'(src_a), 64'(exp_src[k]));
      chk("drain_count", 64'(cnt_a), 64'(3 - k));
      if (k == 0) begin
        chk("drain_bp_clear", 64'(if_a.backpressure_wr), 64'd0);
      end
    end
    chk("drain_rcv", rcv_a, 64'd7);
    chk("drain_lat", lat_a, 64'h508);
    chk("drain_mis", 64'(mis_a), 64'd0);
    chk("drain_ovf_sticky", 64'(ovf_a), 64'd1);

    // Misroute with DRAIN_CYCLE=3 on instance B: pops at E3, E6, E9
    sink_b        = 1'b1;
    if_b.eject_in = pkt(1'b1, 16'h0000, 16'h0021, 16'h0007);
    step();
    chk("mis_e1_count", 64'(cnt_b), 64'd1);
    chk("mis_e1_mis", 64'(mis_b), 64'd0);
    if_b.eject_in = pkt(1'b1, 16'h0000, 16'h0022, 16'h0007);
    step();
    chk("mis_e2_count", 64'(cnt_b), 64'd2);
    chk("mis_e2_mis", 64'(mis_b), 64'd0);
    if_b.eject_in = pkt(1'b1, 16'h0000, 16'h0023, 16'h0007);
    step();
    chk("mis_e3_mis", 64'(mis_b), 64'd1);
    chk("mis_e3_count", 64'(cnt_b), 64'd2);
    chk("mis_e3_src", 64'(src_b), 64'h21);
    if_b.eject_in = 49'd0;
    for (int e = 4; e <= 9; e++) begin
      step();
      chk("mis_cnt", 64'(mis_b), (e >= 9) ? 64'd3 : ((e >= 6) ? 64'd2 : 64'd1));
      chk("mis_fifo", 64'(cnt_b), (e >= 9) ? 64'd0 : ((e >= 6) ? 64'd1 : 64'd2));
      if (e == 6) chk("mis_e6_src", 64'(src_b), 64'h22);
      if (e == 9) chk("mis_e9_src", 64'(src_b), 64'h23);
    end
    chk("mis_rcv", rcv_b, 64'd0);
    chk("mis_lat", lat_b, 64'd0);

    // Reset mid-operation with three packets stored
    sink_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_a.eject_in = pkt(1'b1, 16'h0000, 16'(16'h0030 + i), 16'h0002);
      step();
    end
    if_a.eject_in = 49'd0;
    chk("mid_pre_count", 64'(cnt_a), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_count", 64'(cnt_a), 64'd0);
    chk("mid_rcv", rcv_a, 64'd0);
    chk("mid_lat", lat_a, 64'd0);
    chk("mid_drop", 64'(drop_a), 64'd0);
    chk("mid_ovf", 64'(ovf_a), 64'd0);
    chk("mid_src", 64'(src_a), 64'd0);
    chk("mid_bp", 64'(if_a.backpressure_wr), 64'd0);
    chk("mid_mis_b", 64'(mis_b), 64'd0);
    #1 rst_n = 1'b1;
    sink_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    chk("post_rcv", rcv_a, 64'd0);
    chk("post_count", 64'(cnt_a), 64'd0);
    chk("post_src", 64'(src_a), 64'd0);
    chk("post_mis", 64'(mis_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
